// File: rtl/acc_pkg.sv
// acc_pkg: shared definitions for the parametrised accumulator unit.
// Holds the opcode encodings, the bit positions of the flag vector
// {ZF, CF, OF, SF}, and the control FSM state encoding.
// Build option: ACC_MUL_EN enables the shift-add multiplier (opcode 10).
package acc_pkg;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_LOAD = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_NOT  = 4'd6;
    localparam logic [3:0] OP_SHL  = 4'd7;
    localparam logic [3:0] OP_SHR  = 4'd8;
    localparam logic [3:0] OP_CLR  = 4'd9;
    localparam logic [3:0] OP_MUL  = 4'd10;

    localparam int FLAG_ZF = 3;
    localparam int FLAG_CF = 2;
    localparam int FLAG_OF = 1;
    localparam int FLAG_SF = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/acc_unit_p_if.sv
// acc_unit_p_if: request/response bundle of the accumulator unit.
// master: requester side (drives flush, op_valid, opcode, src_sel,
//         br_in, ir_in; observes op_ready, acc_out, mr_out, flags,
//         done, err).
// slave:  the accumulator unit itself (opposite directions).
interface acc_unit_p_if #(
    parameter int WIDTH = 16
);
    logic             flush;
    logic             op_valid;
    logic             op_ready;
    logic [3:0]       opcode;
    logic             src_sel;
    logic [WIDTH-1:0] br_in;
    logic [WIDTH-1:0] ir_in;
    logic [WIDTH-1:0] acc_out;
    logic [WIDTH-1:0] mr_out;
    logic [3:0]       flags;
    logic             done;
    logic             err;

    modport master (
        output flush, op_valid, opcode, src_sel, br_in, ir_in,
        input  op_ready, acc_out, mr_out, flags, done, err
    );

    modport slave (
        input  flush, op_valid, opcode, src_sel, br_in, ir_in,
        output op_ready, acc_out, mr_out, flags, done, err
    );
endinterface

// File: rtl/acc_alu_comb.sv
// acc_alu_comb: combinational single-cycle datapath of the accumulator.
// Ports:
//   op     - opcode of the request being accepted
//   acc    - current accumulator value
//   b      - selected B operand
//   result - new accumulator value for single-cycle opcodes
//   flags  - {ZF, CF, OF, SF} belonging to result
//   writes - high for opcodes LOAD..CLR, which update ACC and flags
module acc_alu_comb
    import acc_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             writes
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;
    logic           cf;
    logic           of;

    // One extra bit on both paths: bit WIDTH is the carry for ADD and
    // the borrow (acc < b unsigned) for SUB.
    assign sum  = {1'b0, acc} + {1'b0, b};
    assign diff = {1'b0, acc} - {1'b0, b};

    // Result selection; signed overflow is judged from operand and
    // result sign bits (same-sign add flips, mixed-sign sub flips).
    always_comb begin
        result = acc;
        cf     = 1'b0;
        of     = 1'b0;
        writes = 1'b1;
        case (op)
            OP_LOAD: result = b;
            OP_ADD: begin
                result = sum[WIDTH-1:0];
                cf     = sum[WIDTH];
                of     = (acc[WIDTH-1] == b[WIDTH-1]) &&
                         (sum[WIDTH-1] != acc[WIDTH-1]);
            end
            OP_SUB: begin
                result = diff[WIDTH-1:0];
                cf     = diff[WIDTH];
                of     = (acc[WIDTH-1] != b[WIDTH-1]) &&
                         (diff[WIDTH-1] != acc[WIDTH-1]);
            end
            OP_AND: result = acc & b;
            OP_OR:  result = acc | b;
            OP_NOT: result = ~acc;
            OP_SHL: begin
                result = {acc[WIDTH-2:0], 1'b0};
                cf     = acc[WIDTH-1];
            end
            OP_SHR: begin
                result = {1'b0, acc[WIDTH-1:1]};
                cf     = acc[0];
            end
            OP_CLR: result = '0;
            default: writes = 1'b0;
        endcase
    end

    always_comb begin
        flags          = '0;
        flags[FLAG_ZF] = (result == '0);
        flags[FLAG_CF] = cf;
        flags[FLAG_OF] = of;
        flags[FLAG_SF] = result[WIDTH-1];
    end

endmodule

// File: rtl/acc_unit_p.sv
// acc_unit_p: parametrised accumulator unit (ACC + high-product MR).
// Ports:
//   clk   - clock
//   rst_n - asynchronous active-low reset
//   bus   - acc_unit_p_if.slave: flush, op_valid/op_ready handshake,
//           opcode, src_sel, br_in, ir_in, acc_out, mr_out, flags,
//           done, err
// Build option: ACC_MUL_EN adds the WIDTH-cycle shift-add multiplier
// (opcode 10) and the BUSY state; without it opcode 10 is illegal and
// the unit is always ready.
module acc_unit_p
    import acc_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic         clk,
    input  logic         rst_n,
    acc_unit_p_if.slave  bus
);

    state_t           state;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] mr_q;
    logic [3:0]       flags_q;
    logic             done_q;
    logic             err_q;

    logic [WIDTH-1:0] b_sel;
    logic [WIDTH-1:0] alu_result;
    logic [3:0]       alu_flags;
    logic             alu_writes;
    logic             accept;
    logic             op_is_mul;
    logic             op_illegal;

    assign b_sel = bus.src_sel ? bus.ir_in : bus.br_in;

    // flush wins over a pending request while idle.
    assign accept = bus.op_valid && (state == ST_IDLE) && !bus.flush;

    acc_alu_comb #(.WIDTH(WIDTH)) u_alu (
        .op     (bus.opcode),
        .acc    (acc_q),
        .b      (b_sel),
        .result (alu_result),
        .flags  (alu_flags),
        .writes (alu_writes)
    );

`ifdef ACC_MUL_EN
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] pp_hi;
    logic [WIDTH-1:0] pp_lo;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH:0]   step_sum;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;
    logic [3:0]       mul_flags;

    assign op_is_mul = (bus.opcode == OP_MUL);

    // One shift-add step: pp_lo starts as the multiplier and is shifted
    // out from the bottom while product bits enter from pp_hi, so after
    // WIDTH steps {pp_hi, pp_lo} holds the full product.
    always_comb begin
        step_sum = {1'b0, pp_hi} + (pp_lo[0] ? {1'b0, mcand} : '0);
        step_hi  = step_sum[WIDTH:1];
        step_lo  = {step_sum[0], pp_lo[WIDTH-1:1]};
    end

    always_comb begin
        mul_flags          = '0;
        mul_flags[FLAG_ZF] = ({step_hi, step_lo} == '0);
        mul_flags[FLAG_CF] = (step_hi != '0);
        mul_flags[FLAG_OF] = (step_hi != '0);
        mul_flags[FLAG_SF] = step_hi[WIDTH-1];
    end
`else
    assign op_is_mul = 1'b0;
`endif

    assign op_illegal = !alu_writes && (bus.opcode != OP_NOP) && !op_is_mul;

    // Control FSM and all architectural registers. ACC/MR/flags are only
    // written on completion, so a running MUL leaves them untouched and
    // a flush simply drops the partial product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            acc_q   <= '0;
            mr_q    <= '0;
            flags_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef ACC_MUL_EN
            cnt     <= '0;
            pp_hi   <= '0;
            pp_lo   <= '0;
            mcand   <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (op_is_mul) begin
`ifdef ACC_MUL_EN
                            state <= ST_BUSY;
                            cnt   <= CNT_W'(WIDTH - 1);
                            pp_hi <= '0;
                            pp_lo <= acc_q;
                            mcand <= b_sel;
`endif
                        end else if (alu_writes) begin
                            acc_q   <= alu_result;
                            flags_q <= alu_flags;
                            done_q  <= 1'b1;
                            if (bus.opcode == OP_CLR) begin
                                mr_q <= '0;
                            end
                        end else if (op_illegal) begin
                            err_q <= 1'b1;
                        end
                    end
                end
`ifdef ACC_MUL_EN
                ST_BUSY: begin
                    if (bus.flush) begin
                        state <= ST_IDLE;
                    end else begin
                        pp_hi <= step_hi;
                        pp_lo <= step_lo;
                        if (cnt == '0) begin
                            acc_q   <= step_lo;
                            mr_q    <= step_hi;
                            flags_q <= mul_flags;
                            done_q  <= 1'b1;
                            state   <= ST_IDLE;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.op_ready = (state == ST_IDLE);
    assign bus.acc_out  = acc_q;
    assign bus.mr_out   = mr_q;
    assign bus.flags    = flags_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_acc_unit_p.sv
// tb_acc_unit_p: self-checking bench for acc_unit_p (WIDTH=16).
// Directed steps followed by randomized back-to-back requests, checked
// against an arithmetic reference model. MUL checks are built only when
// ACC_MUL_EN is defined; otherwise opcode 10 is checked as illegal.
module tb_acc_unit_p;
    import acc_pkg::*;

    localparam int W = 16;
    localparam longint unsigned FULL = 64'd1 << W;
    localparam longint unsigned HALF = 64'd1 << (W - 1);

    logic clk;
    logic rst_n;
    int   compared;
    int   mismatched;

    logic [W-1:0] m_acc;
    logic [W-1:0] m_mr;
    logic [3:0]   m_flags;

    acc_unit_p_if #(.WIDTH(W)) bus ();

    acc_unit_p #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: every check funnels through here.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic longint sx(input longint unsigned v);
        return (v >= HALF) ? longint'(v) - longint'(FULL) : longint'(v);
    endfunction

    // Reference model: plain wide-integer arithmetic on the model state.
    task automatic modelOp(input logic [3:0] op, input logic [W-1:0] b,
                           output bit expDone, output bit expErr);
        longint unsigned a, bb, r, p;
        longint          sr;
        bit              cf, of, isMul;
        a = m_acc; bb = b; r = a; cf = 0; of = 0; isMul = 0;
        expDone = 1; expErr = 0;
        case (op)
            OP_NOP:  expDone = 0;
            OP_LOAD: r = bb;
            OP_ADD: begin
                r = a + bb; cf = (r >= FULL);
                sr = sx(a) + sx(bb); of = (sr >= longint'(HALF)) || (sr < -longint'(HALF));
            end
            OP_SUB: begin
                r = a + FULL - bb; cf = (a < bb);
                sr = sx(a) - sx(bb); of = (sr >= longint'(HALF)) || (sr < -longint'(HALF));
            end
            OP_AND:  r = a & bb;
            OP_OR:   r = a | bb;
            OP_NOT:  r = (FULL - 1) - a;
            OP_SHL: begin r = a * 2; cf = (a >= HALF); end
            OP_SHR: begin r = a / 2; cf = (a % 2 == 1); end
            OP_CLR: begin r = 0; m_mr = '0; end
`ifdef ACC_MUL_EN
            OP_MUL: begin
                isMul = 1; p = a * bb;
                m_acc = W'(p % FULL);
                m_mr  = W'(p / FULL);
                m_flags = {p == 0, m_mr != 0, m_mr != 0, m_mr[W-1]};
            end
`endif
            default: begin expDone = 0; expErr = 1; end
        endcase
        if (expDone && !isMul) begin
            r = r % FULL;
            m_acc = W'(r);
            m_flags = {r == 0, cf, of, r >= HALF};
        end
    endtask

    // Present one request at the falling edge; return #1 after the
    // rising edge that samples it. op_valid is left high on purpose so
    // consecutive calls form back-to-back requests.
    task automatic applyStimulus(input logic [3:0] op, input logic src, input logic [W-1:0] br,
                                 input logic [W-1:0] ir, input logic fl);
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.opcode   = op;
        bus.src_sel  = src;
        bus.br_in    = br;
        bus.ir_in    = ir;
        bus.flush    = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input bit expDone, input bit expErr, input bit expReady);
        check({tag, "_acc"},   32'(bus.acc_out),  32'(m_acc));
        check({tag, "_mr"},    32'(bus.mr_out),   32'(m_mr));
        check({tag, "_flags"}, 32'(bus.flags),    32'(m_flags));
        check({tag, "_done"},  32'(bus.done),     32'(expDone));
        check({tag, "_err"},   32'(bus.err),      32'(expErr));
        check({tag, "_ready"}, 32'(bus.op_ready), 32'(expReady));
    endtask

    task automatic doOp(input logic [3:0] op, input logic src, input logic [W-1:0] br,
                        input logic [W-1:0] ir, input logic fl, input string tag);
        bit d, e;
        applyStimulus(op, src, br, ir, fl);
        bus.flush = 1'b0;
        if (fl) begin d = 0; e = 0; end
        else modelOp(op, src ? ir : br, d, e);
        checkOutput(tag, d, e, 1'b1);
    endtask

`ifdef ACC_MUL_EN
    // Pulse a MUL request and wait (bounded) for its completion.
    task automatic runMul(input logic [W-1:0] b, input string tag);
        int  cyc;
        bit  d, e;
        applyStimulus(OP_MUL, 1'b0, b, '0, 1'b0);
        bus.op_valid = 1'b0;
        cyc = 0;
        while (!bus.done && cyc < 3 * W) begin
            @(posedge clk); #1; cyc++;
        end
        modelOp(OP_MUL, b, d, e);
        check({tag, "_latency"}, 32'(cyc), 32'(W));
        checkOutput(tag, d, e, 1'b1);
    endtask
`endif

    initial begin
        logic [3:0] op;
        int         lowCycles, doneSeen;
        bit         accHeld;
        bit         d, e;
        compared = 0; mismatched = 0;
        rst_n = 1'b0;
        bus.flush = 1'b0; bus.op_valid = 1'b0; bus.opcode = '0;
        bus.src_sel = 1'b0; bus.br_in = '0; bus.ir_in = '0;
        m_acc = '0; m_mr = '0; m_flags = '0;

        #12;
        checkOutput("reset", 0, 0, 1);
        @(negedge clk);
        rst_n = 1'b1;

        doOp(OP_LOAD, 0, 16'h7FFF, 16'h0, 0, "load7fff");
        doOp(OP_ADD,  0, 16'h0001, 16'h0, 0, "add1");
        check("add1_acc_const",   32'(bus.acc_out), 32'h8000);
        check("add1_flags_const", 32'(bus.flags),   32'b0011);

        doOp(OP_LOAD, 0, 16'h0003, 16'h0, 0, "load3");
        doOp(OP_SUB,  1, 16'hAAAA, 16'h0005, 0, "sub5");
        check("sub5_acc_const",   32'(bus.acc_out), 32'hFFFE);
        check("sub5_flags_const", 32'(bus.flags),   32'b0101);

        doOp(OP_LOAD, 0, 16'h8001, 16'h0, 0, "load8001");
        doOp(OP_SHL,  0, 16'h0, 16'h0, 0, "shl");
        check("shl_acc_const",   32'(bus.acc_out), 32'h0002);
        check("shl_flags_const", 32'(bus.flags),   32'b0100);
        doOp(OP_SHR,  0, 16'h0, 16'h0, 0, "shr");
        check("shr_acc_const",   32'(bus.acc_out), 32'h0001);
        check("shr_flags_const", 32'(bus.flags),   32'b0000);

        doOp(4'd13, 0, 16'h5555, 16'h0, 0, "illegal13");
        doOp(OP_NOP, 0, 16'h5555, 16'h0, 0, "nop");
        doOp(OP_LOAD, 0, 16'hBEEF, 16'h0, 1, "flush_idle");
        check("flush_idle_acc_const", 32'(bus.acc_out), 32'h0001);

`ifdef ACC_MUL_EN
        // MUL with the request held high for the whole operation.
        doOp(OP_LOAD, 0, 16'h1234, 16'h0, 0, "load1234");
        applyStimulus(OP_MUL, 0, 16'h0100, 16'h0, 0);
        lowCycles = 0; doneSeen = 0; accHeld = 1;
        while (!bus.op_ready && lowCycles < 3 * W) begin
            lowCycles++;
            if (bus.done) doneSeen++;
            if (bus.acc_out !== m_acc || bus.mr_out !== m_mr) accHeld = 0;
            @(posedge clk); #1;
        end
        bus.op_valid = 1'b0;
        check("mulheld_ready_low", 32'(lowCycles), 32'(W));
        check("mulheld_early_done", 32'(doneSeen), 32'd0);
        check("mulheld_acc_held", 32'(accHeld), 32'd1);
        modelOp(OP_MUL, 16'h0100, d, e);
        checkOutput("mulheld", d, e, 1);
        check("mulheld_acc_const",   32'(bus.acc_out), 32'h3400);
        check("mulheld_mr_const",    32'(bus.mr_out),  32'h0012);
        check("mulheld_flags_const", 32'(bus.flags),   32'b0110);
        @(posedge clk); #1;
        checkOutput("mulheld_after", 0, 0, 1);

        // Flush sampled on the fifth edge after the accept edge.
        doOp(OP_LOAD, 0, 16'hC3A5, 16'h0, 0, "load_fl");
        applyStimulus(OP_MUL, 0, 16'h7777, 16'h0, 0);
        bus.op_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        checkOutput("mul_flush", 0, 0, 1);
        repeat (W) begin
            @(posedge clk); #1;
            check("mul_flush_nodone", 32'(bus.done), 32'd0);
        end

        // Asynchronous reset in the middle of a MUL.
        applyStimulus(OP_MUL, 0, 16'h4321, 16'h0, 0);
        bus.op_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        m_acc = '0; m_mr = '0; m_flags = '0;
        checkOutput("mul_reset", 0, 0, 1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            doOp(OP_LOAD, 0, 16'($urandom), 16'h0, 0, $sformatf("mload%0d", i));
            runMul(16'($urandom), $sformatf("mrnd%0d", i));
        end
        runMul(16'h0000, "mul_zero");
`else
        doOp(OP_MUL, 0, 16'h0100, 16'h0, 0, "mul_disabled");
        check("mul_disabled_acc_const", 32'(bus.acc_out), 32'h0001);
`endif

        // Randomized back-to-back requests, occasional idle flush.
        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 15));
`ifdef ACC_MUL_EN
            if (op == OP_MUL) op = OP_ADD;
`endif
            doOp(op, 1'($urandom), 16'($urandom), 16'($urandom),
                 ($urandom_range(0, 9) == 0), $sformatf("rnd%0d_op%0d", i, op));
        end
        bus.op_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Absolute time bound so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: observed=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
